// File: rtl/cc_cond_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : cc_cond_unit                                           |
// | Description : Execute-stage condition-code register, jump/cmov       |
// |               condition evaluator and execute-to-memory pipeline     |
// |               register for the ALU result and condition.             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module cc_cond_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] alu_out,
  input  logic        alu_of,
  input  logic        set_cc,
  input  logic        cc_block,
  input  logic [3:0]  ifun,
  input  logic        m_stall,
  input  logic        m_bubble,
  output logic [2:0]  cc,
  output logic        e_cnd,
  output logic [63:0] m_vale,
  output logic        m_cnd
);

  // Condition-code reset value: ZF set, SF and OF clear.
  localparam logic [2:0] c_CC_RESET = 3'b100;

  // Function codes selecting the jump / conditional-move condition.
  localparam logic [3:0] c_FN_ALWAYS = 4'd0;
  localparam logic [3:0] c_FN_LE     = 4'd1;
  localparam logic [3:0] c_FN_L      = 4'd2;
  localparam logic [3:0] c_FN_E      = 4'd3;
  localparam logic [3:0] c_FN_NE     = 4'd4;
  localparam logic [3:0] c_FN_GE     = 4'd5;
  localparam logic [3:0] c_FN_G      = 4'd6;

  logic [2:0]  r_cc;
  logic [63:0] r_m_vale;
  logic        r_m_cnd;

  logic [2:0]  w_cc_new;
  logic        w_cc_we;
  logic        w_zf;
  logic        w_sf;
  logic        w_of;
  logic        w_sf_xor_of;
  logic        w_cnd;

  // Flags derived from the current ALU result; written only by a flag-setting
  // instruction that no later-stage exception has cancelled.
  assign w_cc_new = {(alu_out == 64'd0), alu_out[63], alu_of};
  assign w_cc_we  = set_cc && !cc_block;

  // Condition evaluation always looks at the stored flags, i.e. the flags of
  // the previous flag-setting instruction.
  assign w_zf        = r_cc[2];
  assign w_sf        = r_cc[1];
  assign w_of        = r_cc[0];
  assign w_sf_xor_of = w_sf ^ w_of;

  // Condition-code register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cc <= c_CC_RESET;
    end else if (w_cc_we) begin
      r_cc <= w_cc_new;
    end
  end

  // Decode the selected condition from the stored flags; reserved codes are false.
  always_comb begin
    w_cnd = 1'b0;
    case (ifun)
      c_FN_ALWAYS: w_cnd = 1'b1;
      c_FN_LE:     w_cnd = w_sf_xor_of | w_zf;
      c_FN_L:      w_cnd = w_sf_xor_of;
      c_FN_E:      w_cnd = w_zf;
      c_FN_NE:     w_cnd = !w_zf;
      c_FN_GE:     w_cnd = !w_sf_xor_of;
      c_FN_G:      w_cnd = !w_sf_xor_of && !w_zf;
      default:     w_cnd = 1'b0;
    endcase
  end

  // Memory-stage pipeline register: a bubble overrides a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_vale <= 64'd0;
      r_m_cnd  <= 1'b0;
    end else if (m_bubble) begin
      r_m_vale <= 64'd0;
      r_m_cnd  <= 1'b0;
    end else if (!m_stall) begin
      r_m_vale <= alu_out;
      r_m_cnd  <= w_cnd;
    end
  end

  assign cc     = r_cc;
  assign e_cnd  = w_cnd;
  assign m_vale = r_m_vale;
  assign m_cnd  = r_m_cnd;

endmodule
`default_nettype wire

// File: tb/tb_cc_cond_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_cc_cond_unit                                        |
// | Description : Directed self-checking bench for cc_cond_unit.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_cc_cond_unit;

  logic        clk;
  logic        rst;
  logic [63:0] alu_out;
  logic        alu_of;
  logic        set_cc;
  logic        cc_block;
  logic [3:0]  ifun;
  logic        m_stall;
  logic        m_bubble;
  logic [2:0]  cc;
  logic        e_cnd;
  logic [63:0] m_vale;
  logic        m_cnd;

  int checks;
  int errors;

  cc_cond_unit dut (
    .clk      (clk),
    .rst      (rst),
    .alu_out  (alu_out),
    .alu_of   (alu_of),
    .set_cc   (set_cc),
    .cc_block (cc_block),
    .ifun     (ifun),
    .m_stall  (m_stall),
    .m_bubble (m_bubble),
    .cc       (cc),
    .e_cnd    (e_cnd),
    .m_vale   (m_vale),
    .m_cnd    (m_cnd)
  );

  // 10 time-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; sampling and driving happen 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Condition table written out per flag combination {ZF,SF,OF}.
  function automatic logic exp_cnd(input logic [2:0] f, input logic [3:0] fn);
    logic lt;
    lt = (f[1] != f[0]);
    case (fn)
      4'd0:    return 1'b1;
      4'd1:    return lt || (f[2] == 1'b1);
      4'd2:    return lt;
      4'd3:    return f[2];
      4'd4:    return ~f[2];
      4'd5:    return ~lt;
      4'd6:    return (~lt) && (f[2] == 1'b0);
      default: return 1'b0;
    endcase
  endfunction

  logic [63:0] vec_alu [6];
  logic        vec_of  [6];
  logic [2:0]  vec_cc  [6];

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b0;
    alu_out  = 64'd0;
    alu_of   = 1'b0;
    set_cc   = 1'b0;
    cc_block = 1'b0;
    ifun     = 4'd3;
    m_stall  = 1'b0;
    m_bubble = 1'b0;

    vec_alu[0] = 64'd0;                  vec_of[0] = 1'b0; vec_cc[0] = 3'b100;
    vec_alu[1] = 64'd0;                  vec_of[1] = 1'b1; vec_cc[1] = 3'b101;
    vec_alu[2] = 64'd1;                  vec_of[2] = 1'b0; vec_cc[2] = 3'b000;
    vec_alu[3] = 64'd1;                  vec_of[3] = 1'b1; vec_cc[3] = 3'b001;
    vec_alu[4] = 64'h8000_0000_0000_0000; vec_of[4] = 1'b0; vec_cc[4] = 3'b010;
    vec_alu[5] = 64'h8000_0000_0000_0000; vec_of[5] = 1'b1; vec_cc[5] = 3'b011;

    // Reset asserted between clock edges takes effect immediately.
    #2;
    rst = 1'b1;
    #1;
    chk("reset_cc", {61'd0, cc}, 64'h4);
    chk("reset_m_vale", m_vale, 64'd0);
    chk("reset_m_cnd", {63'd0, m_cnd}, 64'd0);
    chk("reset_e_cnd_e", {63'd0, e_cnd}, 64'd1);
    ifun = 4'd4;
    #1;
    chk("reset_e_cnd_ne", {63'd0, e_cnd}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Flag capture: negative result with overflow.
    set_cc  = 1'b1;
    alu_out = 64'h8000_0000_0000_0000;
    alu_of  = 1'b1;
    step();
    chk("cap_neg_cc", {61'd0, cc}, 64'h3);
    ifun = 4'd2;
    #1;
    chk("cap_neg_l", {63'd0, e_cnd}, 64'd0);
    ifun = 4'd5;
    #1;
    chk("cap_neg_ge", {63'd0, e_cnd}, 64'd1);

    // Flag capture: zero result.
    alu_out = 64'd0;
    alu_of  = 1'b0;
    step();
    chk("cap_zero_cc", {61'd0, cc}, 64'h4);
    ifun = 4'd1;
    #1;
    chk("cap_zero_le", {63'd0, e_cnd}, 64'd1);
    ifun = 4'd6;
    #1;
    chk("cap_zero_g", {63'd0, e_cnd}, 64'd0);

    // Blocked update and no-update cases leave cc alone.
    cc_block = 1'b1;
    alu_out  = 64'd5;
    step();
    chk("blocked_cc", {61'd0, cc}, 64'h4);
    cc_block = 1'b0;
    set_cc   = 1'b0;
    alu_out  = 64'hFFFF_FFFF_FFFF_FFFF;
    alu_of   = 1'b1;
    step();
    chk("no_set_cc", {61'd0, cc}, 64'h4);

    // Every reachable flag combination against every function code.
    for (int v = 0; v < 6; v++) begin
      set_cc  = 1'b1;
      alu_out = vec_alu[v];
      alu_of  = vec_of[v];
      step();
      set_cc = 1'b0;
      chk($sformatf("sweep_cc_%0d", v), {61'd0, cc}, {61'd0, vec_cc[v]});
      for (int f = 0; f < 16; f++) begin
        ifun = 4'(f);
        #1;
        chk($sformatf("sweep_cnd_cc%0b_fn%0d", vec_cc[v], f), {63'd0, e_cnd},
            {63'd0, exp_cnd(vec_cc[v], 4'(f))});
      end
    end

    // Memory-stage load, stall, bubble.
    set_cc  = 1'b0;
    alu_of  = 1'b0;
    ifun    = 4'd0;
    alu_out = 64'h1234;
    step();
    chk("mem_load_vale", m_vale, 64'h1234);
    chk("mem_load_cnd", {63'd0, m_cnd}, 64'd1);
    m_stall = 1'b1;
    alu_out = 64'd7;
    ifun    = 4'd7;
    step();
    chk("mem_stall_vale", m_vale, 64'h1234);
    chk("mem_stall_cnd", {63'd0, m_cnd}, 64'd1);
    m_bubble = 1'b1;
    ifun     = 4'd0;
    step();
    chk("mem_bubble_stall_vale", m_vale, 64'd0);
    chk("mem_bubble_stall_cnd", {63'd0, m_cnd}, 64'd0);
    m_stall = 1'b0;
    m_bubble = 1'b0;
    step();
    chk("mem_reload_vale", m_vale, 64'd7);
    chk("mem_reload_cnd", {63'd0, m_cnd}, 64'd1);

    // Mid-operation reset pulse shorter than a clock period.
    set_cc  = 1'b1;
    alu_out = 64'h8000_0000_0000_0000;
    alu_of  = 1'b1;
    step();
    set_cc  = 1'b0;
    alu_out = 64'hFF;
    alu_of  = 1'b0;
    step();
    chk("pre_rst_cc", {61'd0, cc}, 64'h3);
    chk("pre_rst_m_vale", m_vale, 64'hFF);
    set_cc = 1'b1;
    ifun   = 4'd3;
    #2;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_cc", {61'd0, cc}, 64'h4);
    chk("mid_rst_m_vale", m_vale, 64'd0);
    chk("mid_rst_m_cnd", {63'd0, m_cnd}, 64'd0);
    step();
    chk("post_rst_cc", {61'd0, cc}, 64'h0);
    chk("post_rst_m_vale", m_vale, 64'hFF);
    chk("post_rst_m_cnd", {63'd0, m_cnd}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
